// File: rtl/bb_master_arbiter_pkg.sv
// Shared types and default sizes for the Blackbone bus master arbiter.
// The state enum is shared so that the RTL and any debug tooling agree on names.
package bb_master_arbiter_pkg;

    localparam int BB_NREQ = 4;
    localparam int BB_AW   = 8;
    localparam int BB_DW   = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ENABLE  = 2'd2,
        CAPTURE = 2'd3
    } bb_mst_st_t;

    // Next index after cur, wrapping modulo n.
    function automatic int unsigned bb_wrap_add(input int unsigned cur, input int unsigned k,
                                                input int unsigned n);
        return (cur + k) % n;
    endfunction

endpackage

// File: rtl/bb_master_arbiter_if.sv
// Requester-side handshake and peripheral bus grouped into one bundle.
// The master modport is the arbiter's view; slave is the environment's view.
interface bb_master_arbiter_if
    import bb_master_arbiter_pkg::*;
#(
    parameter int NREQ = BB_NREQ,
    parameter int AW   = BB_AW,
    parameter int DW   = BB_DW
);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ack;
    logic [DW-1:0]      req_rdata;
    logic               busy;

    logic [AW-1:0]      per_addr;
    logic               per_we;
    logic               per_en;
    logic [DW-1:0]      per_din;
    logic [DW-1:0]      per_dout;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, per_dout,
        output req_ack, req_rdata, busy, per_addr, per_we, per_en, per_din
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, per_dout,
        input  req_ack, req_rdata, busy, per_addr, per_we, per_en, per_din
    );

endinterface

// File: rtl/bb_master_arbiter_rr.sv
// Combinational round-robin picker: first asserted request after ptr_i, wrapping.
module bb_rr_arbiter
    import bb_master_arbiter_pkg::*;
#(
    parameter  int NREQ = BB_NREQ,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic            gnt_valid_o,
    output logic [IW-1:0]   gnt_idx_o
);

    always_comb begin
        int unsigned cand;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        cand        = 0;
        // Walk from farthest to nearest so the nearest requester after ptr wins.
        for (int k = NREQ; k >= 1; k--) begin
            cand = bb_wrap_add(int'(ptr_i), k, NREQ);
            if (req_i[cand]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/bb_master_arbiter.sv
// Round-robin bus master: serialises requester transactions onto the two-phase
// Blackbone peripheral bus, staying in step with the slave's free-running phase.
module bb_master_arbiter
    import bb_master_arbiter_pkg::*;
#(
    parameter  int NREQ = BB_NREQ,
    parameter  int AW   = BB_AW,
    parameter  int DW   = BB_DW,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic              mclk,
    input  logic              mrst,
    bb_master_arbiter_if.master bus
);

    bb_mst_st_t      st_q, st_d;
    logic            slv_setup_q;
    logic            slv_setup_nxt;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [AW-1:0]   per_addr_q, per_addr_d;
    logic            per_we_q, per_we_d;
    logic            per_en_q, per_en_d;
    logic [DW-1:0]   per_din_q, per_din_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0] req_eff;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_idx;

    // The slave leaves SETUP on any cycle it sees per_en low, so it idles by toggling.
    assign slv_setup_nxt = slv_setup_q ? per_en_q : 1'b1;

    // A requester still shows valid during its own ack cycle; keep it out of that decision.
    assign req_eff = bus.req_valid & ~ack_q;

    bb_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i       (req_eff),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        st_d       = st_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        per_addr_d = per_addr_q;
        per_we_d   = per_we_q;
        per_en_d   = per_en_q;
        per_din_d  = per_din_q;
        ack_d      = '0;
        rdata_d    = rdata_q;
        unique case (st_q)
            IDLE: begin
                per_en_d = 1'b0;
                if (gnt_valid && slv_setup_nxt) begin
                    idx_d      = gnt_idx;
                    rr_ptr_d   = gnt_idx;
                    per_addr_d = bus.req_addr[gnt_idx*AW +: AW];
                    per_we_d   = bus.req_we[gnt_idx];
                    per_din_d  = bus.req_wdata[gnt_idx*DW +: DW];
                    st_d       = SETUP;
                end
            end
            SETUP: begin
                per_en_d = 1'b1;
                st_d     = ENABLE;
            end
            ENABLE: begin
                per_en_d = 1'b0;
                if (per_we_q) begin
                    ack_d[idx_q] = 1'b1;
                    st_d         = IDLE;
                end else begin
                    st_d = CAPTURE;
                end
            end
            CAPTURE: begin
                rdata_d      = bus.per_dout;
                ack_d[idx_q] = 1'b1;
                st_d         = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge mrst) begin
        if (!mrst) begin
            st_q        <= IDLE;
            slv_setup_q <= 1'b1;
            rr_ptr_q    <= IW'(NREQ - 1);
            idx_q       <= '0;
            per_addr_q  <= '0;
            per_we_q    <= 1'b0;
            per_en_q    <= 1'b0;
            per_din_q   <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
        end else begin
            st_q        <= st_d;
            slv_setup_q <= slv_setup_nxt;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            per_addr_q  <= per_addr_d;
            per_we_q    <= per_we_d;
            per_en_q    <= per_en_d;
            per_din_q   <= per_din_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus.busy      = (st_q != IDLE);
    assign bus.per_addr  = per_addr_q;
    assign bus.per_we    = per_we_q;
    assign bus.per_en    = per_en_q;
    assign bus.per_din   = per_din_q;
    assign bus.req_ack   = ack_q;
    assign bus.req_rdata = rdata_q;

endmodule

// File: tb/tb_bb_master_arbiter.sv
// Bench for bb_master_arbiter: behavioural two-phase slave memory, reference
// memory and round-robin order model, random and directed transactions.
module tb_bb_master_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 8;
    localparam int DW   = 32;

    logic mclk;
    logic mrst;

    bb_master_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bif ();

    bb_master_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .mclk (mclk),
        .mrst (mrst),
        .bus  (bif)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slave: leaves SETUP whenever per_en is low, returns from ENABLE after one cycle.
    logic          slv_en_ph;
    logic [DW-1:0] smem [256];

    always @(posedge mclk or negedge mrst) begin
        if (!mrst) begin
            slv_en_ph    <= 1'b0;
            bif.per_dout <= '0;
        end else if (!slv_en_ph) begin
            slv_en_ph <= !bif.per_en;
        end else begin
            slv_en_ph <= 1'b0;
            if (bif.per_en) begin
                if (bif.per_we) smem[bif.per_addr] <= bif.per_din;
                else            bif.per_dout       <= smem[bif.per_addr];
            end
        end
    end

    // Bus-level invariants.
    logic prev_en = 1'b0;
    always @(negedge mclk) begin
        if (mrst) begin
            if (bif.per_en) chk("en_consecutive", prev_en, 1'b0);
            if (bif.req_ack != '0) chk("ack_onehot", $onehot(bif.req_ack), 1'b1);
        end
        prev_en <= bif.per_en;
    end

    logic [DW-1:0] ref_mem [256];
    bit            written [256];
    int            rr_last = NREQ - 1;

    task automatic do_txn(input int idx, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input bit drop_early);
        int wt, lat, n;
        logic [NREQ-1:0] acks;
        wt = slv_en_ph ? 0 : 1;
        lat = wt + (we ? 3 : 4);
        bif.req_we[idx]             = we;
        bif.req_addr[idx*AW +: AW]  = addr;
        bif.req_wdata[idx*DW +: DW] = data;
        bif.req_valid[idx]          = 1'b1;
        n = 0;
        acks = '0;
        while (n < lat + 4 && acks == '0) begin
            @(negedge mclk);
            n++;
            if (n == wt + 1) begin
                chk("setup_en", bif.per_en, 1'b0);
                chk("setup_we", bif.per_we, we);
                chk("setup_addr", bif.per_addr, addr);
                chk("setup_busy", bif.busy, 1'b1);
                if (we) chk("setup_din", bif.per_din, data);
                if (drop_early) bif.req_valid[idx] = 1'b0;
            end
            if (n == wt + 2) chk("enable_en", bif.per_en, 1'b1);
            acks = bif.req_ack;
        end
        chk("ack_latency", n, lat);
        chk("ack_vector", acks, NREQ'(1) << idx);
        chk("addr_hold", bif.per_addr, addr);
        if (we) begin
            ref_mem[addr] = data;
            written[addr] = 1'b1;
        end else begin
            chk("rdata", bif.req_rdata, ref_mem[addr]);
        end
        rr_last = idx;
        bif.req_valid[idx] = 1'b0;
        @(negedge mclk);
        chk("ack_pulse", bif.req_ack, '0);
    endtask

    initial begin
        int rem [NREQ];
        logic [AW-1:0] caddr [NREQ];
        logic [DW-1:0] cdata [NREQ];
        int got, exp_idx, nacks, cyc, a;
        bit reraise0, we;
        logic [AW-1:0] ad;

        mrst          = 1'b0;
        bif.req_valid = '0;
        bif.req_we    = '0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        repeat (3) @(negedge mclk);
        chk("rst_en", bif.per_en, 1'b0);
        chk("rst_busy", bif.busy, 1'b0);
        chk("rst_ack", bif.req_ack, '0);
        chk("rst_addr", bif.per_addr, '0);
        chk("rst_rdata", bif.req_rdata, '0);
        mrst = 1'b1;
        @(negedge mclk);

        do_txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
        do_txn(0, 1'b0, 8'h10, 32'h0, 1'b0);

        // All four contend; requester 0 comes back for a second write.
        rem = '{2, 1, 1, 1};
        for (int i = 0; i < NREQ; i++) begin
            caddr[i] = AW'(i);
            cdata[i] = $urandom;
            bif.req_we[i]             = 1'b1;
            bif.req_addr[i*AW +: AW]  = caddr[i];
            bif.req_wdata[i*DW +: DW] = cdata[i];
            bif.req_valid[i]          = 1'b1;
        end
        nacks = 0;
        reraise0 = 1'b0;
        cyc = 0;
        while (nacks < 5 && cyc < 80) begin
            @(negedge mclk);
            cyc++;
            if (reraise0) begin
                caddr[0] = 8'h04;
                cdata[0] = $urandom;
                bif.req_addr[0 +: AW]  = caddr[0];
                bif.req_wdata[0 +: DW] = cdata[0];
                bif.req_valid[0]       = 1'b1;
                reraise0 = 1'b0;
            end
            if (bif.req_ack != '0) begin
                got = 0;
                for (int i = 0; i < NREQ; i++) if (bif.req_ack[i]) got = i;
                exp_idx = -1;
                for (int k = NREQ; k >= 1; k--)
                    if (rem[(rr_last + k) % NREQ] > 0) exp_idx = (rr_last + k) % NREQ;
                chk("rr_order", got, exp_idx);
                ref_mem[caddr[got]] = cdata[got];
                written[caddr[got]] = 1'b1;
                rem[got]--;
                bif.req_valid[got] = 1'b0;
                rr_last = got;
                if (got == 0 && rem[0] > 0) reraise0 = 1'b1;
                nacks++;
            end
        end
        chk("rr_ack_count", nacks, 5);
        @(negedge mclk);

        // Request raised while the slave is in SETUP must wait one cycle.
        cyc = 0;
        while (slv_en_ph && cyc < 4) begin
            @(negedge mclk);
            cyc++;
        end
        do_txn(1, 1'b1, 8'h30, $urandom, 1'b0);
        do_txn(3, 1'b0, 8'h30, 32'h0, 1'b0);

        // Valid withdrawn after grant: the transaction still completes and acks.
        do_txn(2, 1'b1, 8'h31, $urandom, 1'b1);

        // Reset while a read sits in CAPTURE.
        got = slv_en_ph ? 0 : 1;
        bif.req_we[1]            = 1'b0;
        bif.req_addr[AW +: AW]   = 8'h10;
        bif.req_valid[1]         = 1'b1;
        repeat (got + 3) @(negedge mclk);
        chk("capture_busy", bif.busy, 1'b1);
        chk("capture_en", bif.per_en, 1'b0);
        mrst = 1'b0;
        #1;
        chk("abort_en", bif.per_en, 1'b0);
        chk("abort_busy", bif.busy, 1'b0);
        chk("abort_ack", bif.req_ack, '0);
        chk("abort_rdata", bif.req_rdata, '0);
        repeat (2) begin
            @(negedge mclk);
            chk("abort_no_ack", bif.req_ack, '0);
        end
        bif.req_valid[1] = 1'b0;
        mrst = 1'b1;
        rr_last = NREQ - 1;
        @(negedge mclk);
        do_txn(1, 1'b0, 8'h10, 32'h0, 1'b0);

        do_txn(2, 1'b1, 8'h55, 32'hA5A5A5A5, 1'b0);
        do_txn(2, 1'b0, 8'h55, 32'h0, 1'b0);

        // Random single-requester traffic with random idle gaps.
        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(0, 2)) @(negedge mclk);
            ad = AW'($urandom_range(32, 47));
            we = !written[ad] || ($urandom_range(0, 1) == 1);
            do_txn($urandom_range(0, NREQ - 1), we, ad, $urandom, 1'b0);
        end

        for (a = 0; a < 256; a++)
            if (written[a]) chk("slave_mem", smem[a], ref_mem[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1);
    end

endmodule
